timer_display_scan: RTL and testbench

// - Consumes the BCD digits of the irrigation timer (min tens/units, sec tens/units) and drives a
//   4-digit multiplexed common-anode 7-segment display, right-most digit = seconds units.
// - Snapshots digits on a load strobe; scans one digit per SCAN_DIV clocks; blinks while paused.
// - Sits downstream of the seconds/minutes counter chain; output side of the timer datapath.

---
 rtl/timer_display_scan.sv | 157 +++++++++++++++
 tb/tb_timer_display_scan.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/timer_display_scan.sv
// timer_display_scan
//   Drives a 4-digit multiplexed common-anode 7-segment display from the
//   BCD digits of the irrigation timer. The digits are snapshotted on a load
//   strobe, one digit is scanned per SCAN_DIV clocks, and the display blinks
//   while a pause request is active.
//
// Parameters
//   SCAN_DIV  : clocks per digit slot (>= 2)
//   BLINK_DIV : full scan frames (4 slots) per blink half-period (>= 1)
//
// Ports
//   clk    in   system clock, rising edge
//   clear  in   synchronous reset, active-high, dominates everything
//   load   in   snapshot strobe (tie high for continuous capture)
//   sec_u  in   seconds units BCD
//   sec_t  in   seconds tens BCD
//   min_u  in   minutes units BCD
//   min_t  in   minutes tens BCD
//   Us     in   pause request (user stop)
//   alin   in   pause request (supply alarm)
//   seg    out  {g,f,e,d,c,b,a}, active-low
//   dp     out  separator decimal point, active-low
//   an     out  digit enables, active-low; an[0] = sec_u .. an[3] = min_t
//
// Configuration macro
//   LEADING_ZERO_BLANK_EN : when defined, a zero minutes-tens digit is left
//                           dark instead of showing '0'.

module timer_display_scan #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 25
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] sec_u,
    input  logic [3:0] sec_t,
    input  logic [3:0] min_u,
    input  logic [3:0] min_t,
    input  logic       Us,
    input  logic       alin,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int PW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_DIV - 1);

    logic [PW-1:0] presc_reg,    presc_next;
    logic [1:0]    slot_reg,     slot_next;
    logic [FW-1:0] frame_reg,    frame_next;
    logic          blink_on_reg, blink_on_next;
    logic [15:0]   snap_reg,     snap_next;
    logic [6:0]    seg_reg,      seg_next;
    logic          dp_reg,       dp_next;
    logic [3:0]    an_reg,       an_next;

    logic          paused;
    logic          presc_wrap;
    logic          digit_on;
    logic [3:0]    digit [4];

    // Split the snapshot into per-slot digits; slot index == an bit index.
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
        assign digit[gi] = snap_reg[gi*4 +: 4];
    end

    function automatic logic [6:0] decode(input logic [3:0] bcd);
        case (bcd)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h3F;   // non-BCD shows a dash
        endcase
    endfunction

    always_comb begin
        paused     = Us | alin;
        presc_wrap = (presc_reg == PRESC_LAST);

        presc_next    = presc_wrap ? '0 : presc_reg + 1'b1;
        slot_next     = presc_wrap ? slot_reg + 2'd1 : slot_reg;
        frame_next    = frame_reg;
        blink_on_next = blink_on_reg;
        snap_next     = load ? {min_t, min_u, sec_t, sec_u} : snap_reg;

        // Blink timing only runs while paused; releasing the pause restarts
        // it from a fresh ON half-period so the next pause starts lit.
        if (!paused) begin
            frame_next    = '0;
            blink_on_next = 1'b1;
        end else if (presc_wrap && slot_reg == 2'd3) begin
            if (frame_reg == FRAME_LAST) begin
                frame_next    = '0;
                blink_on_next = ~blink_on_reg;
            end else begin
                frame_next = frame_reg + 1'b1;
            end
        end

        // First clock of each slot keeps all anodes off so the previous
        // digit's segments never ghost onto the newly selected digit.
        digit_on = (presc_reg != '0);
`ifdef LEADING_ZERO_BLANK_EN
        if (slot_reg == 2'd3 && digit[3] == 4'd0) begin
            digit_on = 1'b0;
        end
`endif

        seg_next = decode(digit[slot_reg]);
        an_next  = digit_on ? ~(4'b0001 << slot_reg) : 4'hF;
        dp_next  = ~(digit_on && slot_reg == 2'd2);

        if (paused && !blink_on_reg) begin
            seg_next = 7'h7F;
            an_next  = 4'hF;
            dp_next  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            presc_reg    <= '0;
            slot_reg     <= 2'd0;
            frame_reg    <= '0;
            blink_on_reg <= 1'b1;
            snap_reg     <= 16'h0000;
            seg_reg      <= 7'h7F;
            dp_reg       <= 1'b1;
            an_reg       <= 4'hF;
        end else begin
            presc_reg    <= presc_next;
            slot_reg     <= slot_next;
            frame_reg    <= frame_next;
            blink_on_reg <= blink_on_next;
            snap_reg     <= snap_next;
            seg_reg      <= seg_next;
            dp_reg       <= dp_next;
            an_reg       <= an_next;
        end
    end

    assign seg = seg_reg;
    assign dp  = dp_reg;
    assign an  = an_reg;

endmodule

// File: tb/tb_timer_display_scan.sv
// Testbench for timer_display_scan with SCAN_DIV=4, BLINK_DIV=2.
// Stimulus pushes the hand-derived display state expected after each clock
// edge into a queue; a monitor on the falling edge pops and compares.
module tb_timer_display_scan;

    logic       clk = 1'b0;
    logic       clear;
    logic       load;
    logic [3:0] sec_u, sec_t, min_u, min_t;
    logic       Us, alin;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    typedef struct {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        bit         chk_seg;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    timer_display_scan #(.SCAN_DIV(4), .BLINK_DIV(2)) dut (
        .clk   (clk),
        .clear (clear),
        .load  (load),
        .sec_u (sec_u),
        .sec_t (sec_t),
        .min_u (min_u),
        .min_t (min_t),
        .Us    (Us),
        .alin  (alin),
        .seg   (seg),
        .dp    (dp),
        .an    (an)
    );

    always #5 clk = ~clk;

    // Monitor: compares every expectation queued since the last falling edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (an !== e.an || dp !== e.dp || (e.chk_seg && seg !== e.seg)) begin
                n_fail++;
                $display("FAIL %s: got seg=%h dp=%b an=%h, want seg=%h%s dp=%b an=%h",
                         e.name, seg, dp, an, e.seg, e.chk_seg ? "" : "(any)", e.dp, e.an);
            end else begin
                $display("ok   %s: seg=%h dp=%b an=%h", e.name, seg, dp, an);
            end
        end
    end

    task automatic push_exp(input string name, input logic [6:0] s, input logic d,
                            input logic [3:0] a, input bit chk);
        exp_t e;
        e.seg = s; e.dp = d; e.an = a; e.chk_seg = chk; e.name = name;
        exp_q.push_back(e);
    endtask

    // Advance n clocks; k counts edges from the start of a frame (prescaler=0,
    // slot=0 before edge k=0). s0..s3 are the hand-decoded segment codes for
    // slots 0..3; lz says the snapshot minutes-tens digit is zero.
    task automatic run_slots(input string name, input int first, input int n,
                             input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3,
                             input bit dark, input bit lz);
        logic [6:0] segs [4];
        logic [3:0] an_tab [4];
        segs   = '{s0, s1, s2, s3};
        an_tab = '{4'hE, 4'hD, 4'hB, 4'h7};
        for (int k = first; k < first + n; k++) begin
            int p, s;
            p = k % 4;
            s = (k / 4) % 4;
            @(posedge clk);
            #1;
            if (dark)
                push_exp($sformatf("%s k%0d dark", name, k), 7'h7F, 1'b1, 4'hF, 1'b1);
            else if (p == 0)
                push_exp($sformatf("%s k%0d ghost", name, k), 7'h7F, 1'b1, 4'hF, 1'b0);
            else if (s == 3 && lz && LZB)
                push_exp($sformatf("%s k%0d lzb", name, k), 7'h7F, 1'b1, 4'hF, 1'b0);
            else
                push_exp($sformatf("%s k%0d", name, k), segs[s], (s == 2) ? 1'b0 : 1'b1,
                         an_tab[s], 1'b1);
        end
    endtask

    task automatic set_digits(input logic [3:0] mt, input logic [3:0] mu,
                              input logic [3:0] st, input logic [3:0] su);
        min_t = mt; min_u = mu; sec_t = st; sec_u = su;
    endtask

    initial begin
        clear = 1'b1; load = 1'b0; Us = 1'b0; alin = 1'b0;
        set_digits(4'd0, 4'd0, 4'd0, 4'd0);

        // Reset values
        @(posedge clk);
        #1;
        push_exp("reset", 7'h7F, 1'b1, 4'hF, 1'b1);
        clear = 1'b0;

        // Scan sequence with an all-zero snapshot
        run_slots("scan0", 0, 16, 7'h40, 7'h40, 7'h40, 7'h40, 1'b0, 1'b1);

        // 12:34
        load = 1'b1;
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        run_slots("ld1234", 0, 16, 7'h19, 7'h30, 7'h24, 7'h79, 1'b0, 1'b0);

        // Non-BCD seconds units shows a dash
        set_digits(4'd1, 4'd2, 4'd3, 4'hC);
        run_slots("ld123C", 0, 16, 7'h3F, 7'h30, 7'h24, 7'h79, 1'b0, 1'b0);

        // Leading zero on minutes tens
        set_digits(4'd0, 4'd2, 4'd3, 4'd4);
        run_slots("ld0234", 0, 16, 7'h19, 7'h30, 7'h24, 7'h40, 1'b0, 1'b1);

        // User stop: 32 clk lit, 32 dark, then release restores display
        Us = 1'b1;
        run_slots("us_on",  0, 32, 7'h19, 7'h30, 7'h24, 7'h40, 1'b0, 1'b1);
        run_slots("us_off", 0, 32, 7'h19, 7'h30, 7'h24, 7'h40, 1'b1, 1'b1);
        Us = 1'b0;
        run_slots("us_rel", 0, 16, 7'h19, 7'h30, 7'h24, 7'h40, 1'b0, 1'b1);

        // Supply alarm: same blink, released half-way through a dark frame
        alin = 1'b1;
        run_slots("al_on",  0, 32, 7'h19, 7'h30, 7'h24, 7'h40, 1'b0, 1'b1);
        run_slots("al_off", 0, 24, 7'h19, 7'h30, 7'h24, 7'h40, 1'b1, 1'b1);
        alin = 1'b0;
        run_slots("al_rel", 8, 8, 7'h19, 7'h30, 7'h24, 7'h40, 1'b0, 1'b1);

        // Clear mid-scan at slot 2, prescaler 2
        load = 1'b0;
        set_digits(4'd0, 4'd0, 4'd0, 4'd0);
        run_slots("pre_clr", 0, 10, 7'h19, 7'h30, 7'h24, 7'h40, 1'b0, 1'b1);
        clear = 1'b1;
        @(posedge clk);
        #1;
        push_exp("clear_mid", 7'h7F, 1'b1, 4'hF, 1'b1);
        clear = 1'b0;
        run_slots("post_clr", 0, 16, 7'h40, 7'h40, 7'h40, 7'h40, 1'b0, 1'b1);

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
